// File: rtl/phy_pkg.sv
// Shared PHY definitions: idle/comma byte, lock depth and alignment state encoding.
// Used by both the par-to-serial stage and the serial-to-parallel aligner.
package phy_pkg;

    localparam int unsigned BYTE_W             = 8;
    localparam int unsigned BIT_CNT_W          = 3;
    localparam logic [BYTE_W-1:0] COMMA_DEFAULT = 8'hBC;
    localparam int unsigned LOCK_COUNT_DEFAULT = 4;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        LOCKING = 2'd1,
        ACTIVE  = 2'd2
    } align_state_e;

    // Byte captured at a boundary, with its payload/idle qualifier.
    typedef struct packed {
        logic [BYTE_W-1:0] data;
        logic              valid;
    } rx_byte_t;

endpackage

// File: rtl/serial_align_s2p.sv
// Serial-to-parallel converter with COMMA-based byte alignment on the bit clock.
// Locks after LOCK_COUNT boundary-aligned COMMAs; emits bytes one cycle after their last bit.
module serial_align_s2p
    import phy_pkg::*;
#(
    parameter logic [7:0]  COMMA      = COMMA_DEFAULT,
    parameter int unsigned LOCK_COUNT = LOCK_COUNT_DEFAULT
) (
    input  logic       clk32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active,
    output logic       byte_strobe
);

    localparam int unsigned CCNT_W = $clog2(LOCK_COUNT + 1);

    align_state_e          state_q, state_d;
    logic [BYTE_W-1:0]     shift_q, shift_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CCNT_W-1:0]     comma_cnt_q, comma_cnt_d;
    logic [CCNT_W-1:0]     comma_inc_c;
    rx_byte_t              cap_q, cap_d;
    logic                  cap_rdy_q, cap_rdy_d;
    logic [BYTE_W-1:0]     data_out_q, data_out_d;
    logic                  valid_out_q, valid_out_d;
    logic                  strobe_q, strobe_d;
    logic                  active_q, active_d;
    logic                  boundary_c;
    logic                  is_comma_c;

    // Next-state, alignment and output-stage logic
    always_comb begin
        state_d     = state_q;
        shift_d     = {shift_q[BYTE_W-2:0], data_in};
        bit_cnt_d   = bit_cnt_q + BIT_CNT_W'(1);
        comma_cnt_d = comma_cnt_q;
        cap_d       = cap_q;
        cap_rdy_d   = 1'b0;
        data_out_d  = data_out_q;
        valid_out_d = valid_out_q;
        strobe_d    = 1'b0;
        active_d    = (state_q == ACTIVE);

        boundary_c  = (bit_cnt_q == BIT_CNT_W'(7));
        is_comma_c  = (shift_d == COMMA);
        comma_inc_c = comma_cnt_q + CCNT_W'(1);

        unique case (state_q)
            SEARCH: begin
                // First COMMA anywhere fixes the byte phase at this edge
                if (is_comma_c) begin
                    bit_cnt_d   = '0;
                    comma_cnt_d = CCNT_W'(1);
                    state_d     = (LOCK_COUNT <= 1) ? ACTIVE : LOCKING;
                end
            end
            LOCKING: begin
                if (boundary_c) begin
                    if (is_comma_c) begin
                        comma_cnt_d = comma_inc_c;
                        if (comma_inc_c == CCNT_W'(LOCK_COUNT)) begin
                            state_d = ACTIVE;
                        end
                    end else begin
                        comma_cnt_d = '0;
                        state_d     = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                // Lock is sticky; COMMA payload bytes are just idles
                if (boundary_c) begin
                    cap_d.data  = shift_d;
                    cap_d.valid = !is_comma_c;
                    cap_rdy_d   = 1'b1;
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase

        if (cap_rdy_q) begin
            data_out_d  = cap_q.data;
            valid_out_d = cap_q.valid;
            strobe_d    = 1'b1;
        end
    end

    always_ff @(posedge clk32f or negedge reset) begin
        if (!reset) begin
            state_q     <= SEARCH;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            comma_cnt_q <= '0;
            cap_q       <= '0;
            cap_rdy_q   <= 1'b0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            strobe_q    <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            comma_cnt_q <= comma_cnt_d;
            cap_q       <= cap_d;
            cap_rdy_q   <= cap_rdy_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            strobe_q    <= strobe_d;
            active_q    <= active_d;
        end
    end

    assign data_out    = data_out_q;
    assign valid_out   = valid_out_q;
    assign byte_strobe = strobe_q;
    assign active      = active_q;

endmodule

// File: doc/serial_align_s2p.md
SERIAL_ALIGN_S2P -- requirements
Module: serial_align_s2p

Interface
REQ-001 The module SHALL have parameter COMMA, default 8'hBC, the idle/alignment byte (K28.5 data value).
REQ-002 The module SHALL have parameter LOCK_COUNT, default 4, the consecutive aligned COMMA bytes required for lock.
REQ-003 The module SHALL have port clk32f, input, 1, the single serial bit clock; all logic on its rising edge.
REQ-004 The module SHALL have port reset, input, 1, the asynchronous active-low reset (0 = in reset).
REQ-005 The module SHALL have port data_in, input, 1, serial bit from the par-to-serial stage, MSB first.
REQ-006 The module SHALL have port data_out, output, 8, the recovered byte.
REQ-007 The module SHALL have port valid_out, output, 1, high when data_out carries a payload (non-COMMA) byte.
REQ-008 The module SHALL have port active, output, 1, high while byte alignment is locked.
REQ-009 The module SHALL have port byte_strobe, output, 1, a one-cycle pulse per recovered byte while active.

Function
REQ-010 The module SHALL shift data_in into an 8-bit register each clk32f edge, new bit into bit 0, giving an MSB-first window.
REQ-011 The module SHALL implement a state machine with states SEARCH, LOCKING and ACTIVE; the reset state is SEARCH.
REQ-012 In SEARCH, the first edge whose updated window equals COMMA SHALL set boundary phase there, set comma count to 1 and go to LOCKING.
REQ-013 In SEARCH, a non-COMMA window SHALL keep the state unchanged, and the bit counter is don't-care.
REQ-014 Boundaries SHALL recur every 8 edges after the phase is set, via a 3-bit wrapping counter (7 -> 0).
REQ-015 In LOCKING, a boundary window equal to COMMA SHALL increment comma count; on reaching LOCK_COUNT the state SHALL go to ACTIVE.
REQ-016 In LOCKING, a boundary window not equal to COMMA SHALL clear comma count and return the state to SEARCH, with no other output change.
REQ-017 The active output SHALL be registered and SHALL assert on the edge after the boundary completing the LOCK_COUNT-th COMMA.
REQ-018 In ACTIVE, on each boundary, the next edge SHALL set data_out to the window, valid_out to (window != COMMA) and byte_strobe to 1.
REQ-019 The output latency SHALL be exactly 1 clk32f cycle from the edge capturing a byte's last bit.
REQ-020 byte_strobe SHALL be 0 on all non-boundary-following edges; data_out and valid_out SHALL hold between strobes.
REQ-021 ACTIVE SHALL be left only by reset; payload bytes equal to COMMA are treated as idle, never as loss of lock.
REQ-022 Outside ACTIVE, data_out, valid_out and byte_strobe SHALL be 0.

Reset
REQ-023 While reset = 0, the module SHALL asynchronously force state SEARCH, shift register 0, bit counter 0, comma count 0 and all outputs 0.
REQ-024 Reset asserted mid-byte or mid-lock SHALL discard all partial alignment, and relock SHALL require a fresh COMMA plus LOCK_COUNT boundaries.
REQ-025 After reset release, the first edge SHALL sample data_in normally, with no extra synchronisation cycles.

Structure
REQ-026 COMMA default, LOCK_COUNT default and the state encoding (SEARCH=0, LOCKING=1, ACTIVE=2) SHALL live in the shared package phy_pkg, reused by the par-to-serial stage.
REQ-027 The module SHALL be a single module with no sub-module, about 150 lines of RTL.
REQ-028 Clock division to clk4f byte rate SHALL NOT be done here; byte_strobe is the byte-rate qualifier for downstream.

Verification
REQ-029 The bench SHALL release reset, send 5 aligned 8'hBC bytes then 8'hBB, and check active rises 1 cycle after the 4th BC boundary, with data_out=8'hBB, valid_out=1 one cycle after its last bit.
REQ-030 The bench SHALL send 3 stray bits 3'b101 then 4 BC bytes, and check alignment is found at the BC boundary despite the offset, with active asserted.
REQ-031 The bench SHALL send BC, BC, 8'h55, BC x4, and check a return to SEARCH at 8'h55, then lock after the later 4 BC.
REQ-032 The bench SHALL send, while ACTIVE, the pattern AA, BC, 99, and check valid_out 1,0,1 with byte_strobe pulsing every 8 cycles.
REQ-033 The bench SHALL assert reset at bit 4 of a payload byte while ACTIVE, and check all outputs are 0 immediately (asynchronous), with no lock until 4 new BC bytes.
REQ-034 The bench SHALL send continuous 8'h88 with no BC after reset, and check active stays 0 and data_out stays 0 indefinitely.
